// File: rtl/gcd_control_fsm.sv
`default_nettype none
// ============================================================================
// gcd_control_fsm : control FSM for the 16-bit subtractive GCD datapath.
// Optional watchdog timeout enabled by defining GCD_WATCHDOG_EN.
// Revision: 1.0
// ============================================================================
module gcd_control_fsm #(
  parameter int MAX_ITER = 65535,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic gt,
  input  logic lt,
  input  logic eq,
  output logic ldA,
  output logic ldB,
  output logic sel1,
  output logic sel2,
  output logic sel_in,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_step;
  logic             w_cnt_clr;
  logic             w_timeout;

`ifdef GCD_WATCHDOG_EN
  assign w_timeout = (r_cnt >= CNT_W'(MAX_ITER));
`else
  assign w_timeout = 1'b0;
  // Counter is retained for debug visibility only in this build.
  logic unused_dbg;
  assign unused_dbg = (MAX_ITER != 0) ^ (^r_cnt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel_in    = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    w_step    = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next    = S_LOAD_A;
          w_cnt_clr = 1'b1;
        end
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        sel_in   = 1'b1;
        if (in_valid) begin
          ldA    = 1'b1;
          w_next = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        sel_in   = 1'b1;
        if (in_valid) begin
          ldB    = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // eq wins over the timeout so a run finishing on the last step still completes.
        if (eq) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end else if (gt) begin
          ldA    = 1'b1;
          sel2   = 1'b1;
          w_step = 1'b1;
        end else if (lt) begin
          ldB    = 1'b1;
          sel1   = 1'b1;
          w_step = 1'b1;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_step && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef GCD_WATCHDOG_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_next == S_ERR) begin
      r_err <= 1'b1;
    end else if ((r_state == S_IDLE) && start) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_control_fsm.sv
`default_nettype none
// tb_gcd_control_fsm : table-driven bench with a behavioural datapath model
// and a result scoreboard for gcd_control_fsm.
module tb_gcd_control_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, gt, lt, eq, ldA, ldB, sel1, sel2, sel_in, busy, done, err;

  logic [15:0] dp_a = 16'd0;
  logic [15:0] dp_b = 16'd0;
  logic [15:0] data_in = 16'd0;

  assign gt = (dp_a > dp_b);
  assign lt = (dp_a < dp_b);
  assign eq = (dp_a == dp_b);

  always #5 clk = ~clk;

  gcd_control_fsm #(
    .MAX_ITER(16),
    .CNT_W   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .gt      (gt),
    .lt      (lt),
    .eq      (eq),
    .ldA     (ldA),
    .ldB     (ldB),
    .sel1    (sel1),
    .sel2    (sel2),
    .sel_in  (sel_in),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] gcd;
    int          steps;
    int          stall;
    bit          poke;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  logic s_ldA, s_ldB, s_sel1, s_sel2, s_sel_in, s_in_ready, s_busy, s_done, s_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs mid-low phase, then update the datapath model just after the edge.
  task automatic tick();
    logic [15:0] m1, m2, bus;
    #1;
    s_ldA = ldA;       s_ldB = ldB;       s_sel1 = sel1;
    s_sel2 = sel2;     s_sel_in = sel_in; s_in_ready = in_ready;
    s_busy = busy;     s_done = done;     s_err = err;
    m1  = sel1 ? dp_b : dp_a;
    m2  = sel2 ? dp_b : dp_a;
    bus = sel_in ? data_in : (m1 - m2);
    @(posedge clk);
    #1;
    if (s_ldA) dp_a = bus;
    if (s_ldB) dp_b = bus;
    @(negedge clk);
  endtask

  task automatic run_gcd(input vec_t v, output logic [15:0] log, output int nlog);
    int cyc;
    int steps;
    bit seen;
    log = '0;
    nlog = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < v.stall; k++) begin
      in_valid = 1'b0;
      tick();
      chk("stall_in_ready", 32'(s_in_ready), 32'd1);
      chk("stall_ldA", 32'(s_ldA), 32'd0);
    end
    data_in = v.a;
    in_valid = 1'b1;
    tick();
    chk("accept_a_ldA", 32'(s_ldA), 32'd1);
    chk("accept_a_sel_in", 32'(s_sel_in), 32'd1);
    chk("accept_a_busy", 32'(s_busy), 32'd1);
    data_in = v.b;
    tick();
    chk("accept_b_ldB", 32'(s_ldB), 32'd1);
    in_valid = 1'b0;
    data_in = 16'hdead;
    sb.push_back(v.gcd);
    cyc = 0;
    steps = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      start = v.poke && (cyc == 1 || cyc == 2);
      tick();
      cyc++;
      if (s_done) begin
        seen = 1'b1;
      end else if (s_ldA || s_ldB) begin
        if (nlog < 16) begin
          log[nlog] = s_ldA;
          nlog++;
        end
        steps++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", 32'(cyc), 32'(v.steps + 2));
    chk("sub_steps", 32'(steps), 32'(v.steps));
    if (seen && sb.size() > 0) chk("result_A", 32'(dp_a), 32'(sb.pop_front()));
    else chk("scoreboard_pop", 32'(seen), 32'd1);
    tick();
    chk("after_done_busy", 32'(s_busy), 32'd0);
    chk("after_done_done", 32'(s_done), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [15:0] log;
    int nlog;

    vecs[0] = '{16'd48,  16'd18, 16'd6,  4,  0,  1'b0};
    vecs[1] = '{16'd7,   16'd7,  16'd7,  0,  0,  1'b0};
    vecs[2] = '{16'd21,  16'd14, 16'd7,  2,  0,  1'b1};
    vecs[3] = '{16'd0,   16'd0,  16'd0,  0,  0,  1'b0};
    vecs[4] = '{16'd100, 16'd75, 16'd25, 3,  0,  1'b0};
    vecs[5] = '{16'd17,  16'd5,  16'd1,  6,  0,  1'b0};
    vecs[6] = '{16'd9,   16'd6,  16'd3,  2,  10, 1'b0};
    vecs[7] = '{16'd1,   16'd12, 16'd1,  11, 0,  1'b0};

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outputs",
        32'({busy, done, err, ldA, ldB, sel1, sel2, sel_in, in_ready}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort a 48,18 computation mid-RUN with an asynchronous reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    data_in = 16'd48;
    in_valid = 1'b1;
    tick();
    data_in = 16'd18;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", 32'(s_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        32'({busy, done, err, ldA, ldB, sel1, sel2, sel_in, in_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wait_for_start_busy", 32'(s_busy), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      run_gcd(vecs[i], log, nlog);
      if (vecs[i].a == 16'd48 && vecs[i].b == 16'd18) begin
        chk("load_order_count", 32'(nlog), 32'd4);
        chk("load_order_pattern", 32'(log[3:0]), 32'b1011);
      end
    end

`ifdef GCD_WATCHDOG_EN
    begin : wd_test
      int na;
      int cyc;
      bit seen_done;
      bit seen_err;
      na = 0;
      cyc = 0;
      seen_done = 1'b0;
      seen_err = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      data_in = 16'd5;
      in_valid = 1'b1;
      tick();
      data_in = 16'd0;
      tick();
      in_valid = 1'b0;
      while (!seen_err && cyc < 100) begin
        tick();
        cyc++;
        if (s_ldA) na++;
        if (s_done) seen_done = 1'b1;
        if (s_err) seen_err = 1'b1;
      end
      chk("wd_ldA_count", 32'(na), 32'd16);
      chk("wd_err_set", 32'(seen_err), 32'd1);
      chk("wd_no_done", 32'(seen_done), 32'd0);
      tick();
      chk("wd_err_sticky", 32'(s_err), 32'd1);
      chk("wd_idle", 32'(s_busy), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("wd_err_cleared", 32'(s_err), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
